pixel_spi_tx: RTL and testbench

Serializes finished pixel results (is_mandelbrot flag plus 24-bit RGB color) back to the host over a write-only SPI master link, mode 0, MSB first. Sits downstream of the pixel pipeline's color output: a pulse on valid_in captures one result into a small FIFO, and frames are drained onto the SPI pins independently of the compute rate. It is the return path for the SPI coordinate receiver that feeds the Mandelbrot engine.

---
 rtl/pixel_spi_tx.sv | 155 +++++++++++++++
 tb/tb_pixel_spi_tx.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_spi_tx.sv
// pixel_spi_tx: buffers pixel results in a small FIFO and streams each one
// as a 25-bit frame {is_mandelbrot, color} over a write-only SPI mode-0 link,
// MSB first. All pins come from flops and lag the FSM state by one cycle.
module pixel_spi_tx #(
  parameter int DATA_WIDTH = 25,
  parameter int FIFO_DEPTH = 4,
  parameter int CLK_DIV    = 2
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        valid_in,
  input  logic        is_mandelbrot,
  input  logic [23:0] color,
  output logic        ready,
  output logic        overflow,
  output logic        busy,
  output logic        spi_clk_out,
  output logic        spi_cs_n,
  output logic        spi_mosi
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HP_W  = $clog2(2 * DATA_WIDTH);

  localparam logic [CNT_W-1:0] CNT_FULL     = CNT_W'(FIFO_DEPTH);
  localparam logic [DIV_W-1:0] DIV_LAST     = DIV_W'(CLK_DIV - 1);
  localparam logic [HP_W-1:0]  HP_LAST      = HP_W'(2 * DATA_WIDTH - 1);
  localparam logic [HP_W-1:0]  HP_NO_SHIFT  = HP_W'(2 * DATA_WIDTH - 2);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;

  state_t                 state, state_next;
  logic [DATA_WIDTH-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [CNT_W-1:0]       count, count_next;
  logic [DIV_W-1:0]       div_cnt;
  logic [HP_W-1:0]        hp_cnt;
  logic [DATA_WIDTH-1:0]  shift_reg;
  logic                   full, push, pop, div_last;
  logic                   cs_n_d, sclk_d, mosi_d;

  assign full     = (count == CNT_FULL);
  assign push     = valid_in && !full;
  assign pop      = (state == IDLE) && (count != '0);
  assign div_last = (div_cnt == DIV_LAST);

  // FIFO occupancy after this cycle's push/pop
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  // FIFO storage (no reset needed, validity tracked by count)
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= DATA_WIDTH'({is_mandelbrot, color});
  end

  // FIFO pointers and count; pointers wrap naturally at power-of-two depth
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_next;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_next;
  end

  // FSM next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (count != '0)            state_next = SETUP;
      SETUP:   if (div_last)               state_next = SHIFT;
      SHIFT:   if (div_last && hp_cnt == HP_LAST) state_next = GAP;
      GAP:     if (div_last)               state_next = IDLE;
      default:                             state_next = IDLE;
    endcase
  end

  // Divider, half-period counter and shift register; shift on entry to each
  // odd half-period except the final one so the LSB holds to the end
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      div_cnt   <= '0;
      hp_cnt    <= '0;
      shift_reg <= '0;
    end else begin
      if (pop) shift_reg <= mem[rd_ptr];
      if (state_next != state) begin
        div_cnt <= '0;
        hp_cnt  <= '0;
      end else if (state != IDLE) begin
        div_cnt <= div_last ? '0 : div_cnt + DIV_W'(1);
        if (state == SHIFT && div_last) begin
          hp_cnt <= hp_cnt + HP_W'(1);
          if (!hp_cnt[0] && hp_cnt != HP_NO_SHIFT) shift_reg <= shift_reg << 1;
        end
      end
    end
  end

  // FSM output decode (registered below)
  always_comb begin
    cs_n_d = 1'b1;
    sclk_d = 1'b0;
    mosi_d = 1'b0;
    case (state)
      SETUP: begin
        cs_n_d = 1'b0;
        mosi_d = shift_reg[DATA_WIDTH-1];
      end
      SHIFT: begin
        cs_n_d = 1'b0;
        sclk_d = !hp_cnt[0];
        mosi_d = shift_reg[DATA_WIDTH-1];
      end
      default: ;
    endcase
  end

  // Output registers; status flags computed from next-cycle state/count
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      spi_cs_n    <= 1'b1;
      spi_clk_out <= 1'b0;
      spi_mosi    <= 1'b0;
      ready       <= 1'b1;
      busy        <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      spi_cs_n    <= cs_n_d;
      spi_clk_out <= sclk_d;
      spi_mosi    <= mosi_d;
      ready       <= (count_next != CNT_FULL);
      busy        <= (state_next != IDLE) || (count_next != '0);
      overflow    <= valid_in && full;
    end
  end

endmodule

// File: tb/tb_pixel_spi_tx.sv
// Bench for pixel_spi_tx: two instances (CLK_DIV=2 and CLK_DIV=1), a pin-level
// SPI frame capture per instance, and a queue of expected frame words.
module tb_pixel_spi_tx;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        v [2];
  logic        im [2];
  logic [23:0] col [2];
  logic        ready_w [2];
  logic        ovf_w [2];
  logic        busy_w [2];
  logic        sclk_w [2];
  logic        cs_w [2];
  logic        mosi_w [2];

  int     n_tests = 0;
  int     n_fail  = 0;
  longint cyc     = 0;

  typedef struct {
    int          inst;
    logic [24:0] word;
    int          bits;
    int          len;
    longint      start;
    longint      rise0;
  } frame_t;

  frame_t      frames [$];
  logic [24:0] expq [$];

  pixel_spi_tx #(.DATA_WIDTH(25), .FIFO_DEPTH(4), .CLK_DIV(2)) u0 (
    .clk(clk), .nrst(nrst), .valid_in(v[0]), .is_mandelbrot(im[0]), .color(col[0]),
    .ready(ready_w[0]), .overflow(ovf_w[0]), .busy(busy_w[0]),
    .spi_clk_out(sclk_w[0]), .spi_cs_n(cs_w[0]), .spi_mosi(mosi_w[0])
  );

  pixel_spi_tx #(.DATA_WIDTH(25), .FIFO_DEPTH(4), .CLK_DIV(1)) u1 (
    .clk(clk), .nrst(nrst), .valid_in(v[1]), .is_mandelbrot(im[1]), .color(col[1]),
    .ready(ready_w[1]), .overflow(ovf_w[1]), .busy(busy_w[1]),
    .spi_clk_out(sclk_w[1]), .spi_cs_n(cs_w[1]), .spi_mosi(mosi_w[1])
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Pin-level frame capture: samples on the falling clk edge, shifts in mosi
  // at each rising sclk while cs_n is low, logs the frame when cs_n rises.
  for (genvar g = 0; g < 2; g++) begin : g_mon
    initial begin
      logic        pcs, psclk;
      int          lowcnt, nb;
      logic [24:0] sh;
      longint      st, r0;
      pcs = 1'b1; psclk = 1'b0; lowcnt = 0; nb = 0; sh = '0; st = 0; r0 = -1;
      forever begin
        @(negedge clk);
        if (!cs_w[g]) begin
          if (pcs) begin
            st = cyc; lowcnt = 0; nb = 0; sh = '0; r0 = -1;
          end
          lowcnt++;
          if (sclk_w[g] && !psclk) begin
            sh = {sh[23:0], mosi_w[g]};
            nb++;
            if (r0 < 0) r0 = cyc;
          end
        end else if (!pcs) begin
          frames.push_back('{g, sh, nb, lowcnt, st, r0});
        end
        pcs   = cs_w[g];
        psclk = sclk_w[g];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle with the given inputs presented to instance i
  task automatic drive(input int i, input logic vv, input logic m, input logic [23:0] c);
    v[i] = vv; im[i] = m; col[i] = c;
    @(posedge clk);
    #1;
    v[i] = 1'b0;
  endtask

  task automatic wait_frames(input string tag, input int n, input int bound);
    int t = 0;
    while (frames.size() < n && t < bound) begin
      @(posedge clk);
      t++;
    end
    chk($sformatf("%s:frames_timeout", tag), 64'(frames.size() >= n), 64'(1));
  endtask

  task automatic wait_idle(input string tag, input int i, input int bound);
    int t = 0;
    while (busy_w[i] && t < bound) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk($sformatf("%s:idle_timeout", tag), 64'(busy_w[i]), 64'(0));
  endtask

  // Compare captured frames against the expected queue, then clear both
  task automatic check_frames(input string tag, input int inst, input int div, input bit b2b);
    chk($sformatf("%s:count", tag), 64'(frames.size()), 64'(expq.size()));
    for (int k = 0; k < frames.size() && k < expq.size(); k++) begin
      chk($sformatf("%s[%0d]:inst", tag, k), 64'(frames[k].inst), 64'(inst));
      chk($sformatf("%s[%0d]:word", tag, k), 64'(frames[k].word), 64'(expq[k]));
      chk($sformatf("%s[%0d]:bits", tag, k), 64'(frames[k].bits), 64'(25));
      chk($sformatf("%s[%0d]:cs_len", tag, k), 64'(frames[k].len), 64'(div * 51));
      chk($sformatf("%s[%0d]:first_rise", tag, k), 64'(frames[k].rise0 - frames[k].start), 64'(div));
      if (b2b && k > 0)
        chk($sformatf("%s[%0d]:spacing", tag, k),
            64'(frames[k].start - frames[k-1].start), 64'(div * 52 + 1));
    end
    frames.delete();
    expq.delete();
  endtask

  initial begin
    longint      n0;
    logic [23:0] c;
    logic        m;
    logic [23:0] cw [6];
    int          rises, t;
    logic        ps;

    for (int i = 0; i < 2; i++) begin
      v[i] = 1'b0; im[i] = 1'b0; col[i] = '0;
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst%0d:ready", i), 64'(ready_w[i]), 64'(1));
      chk($sformatf("rst%0d:busy", i), 64'(busy_w[i]), 64'(0));
      chk($sformatf("rst%0d:cs_n", i), 64'(cs_w[i]), 64'(1));
      chk($sformatf("rst%0d:sclk", i), 64'(sclk_w[i]), 64'(0));
      chk($sformatf("rst%0d:mosi", i), 64'(mosi_w[i]), 64'(0));
      chk($sformatf("rst%0d:overflow", i), 64'(ovf_w[i]), 64'(0));
    end
    nrst = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("idle:busy", 64'(busy_w[0]), 64'(0));
    chk("idle:cs_n", 64'(cs_w[0]), 64'(1));
    chk("idle:no_frames", 64'(frames.size()), 64'(0));

    // Single frame
    drive(0, 1'b1, 1'b1, 24'h123456);
    n0 = cyc;
    chk("single:busy_after_write", 64'(busy_w[0]), 64'(1));
    expq.push_back(25'h1123456);
    wait_frames("single", 1, 300);
    if (frames.size() > 0) chk("single:cs_start", 64'(frames[0].start - n0), 64'(2));
    check_frames("single", 0, 2, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    chk("single:busy_end", 64'(busy_w[0]), 64'(0));
    chk("single:cs_n_end", 64'(cs_w[0]), 64'(1));

    // Back-to-back strobes
    drive(0, 1'b1, 1'b0, 24'h000001); expq.push_back(25'h0000001);
    chk("b2b:ready1", 64'(ready_w[0]), 64'(1));
    drive(0, 1'b1, 1'b0, 24'hFFFFFF); expq.push_back(25'h0FFFFFF);
    chk("b2b:ready2", 64'(ready_w[0]), 64'(1));
    drive(0, 1'b1, 1'b0, 24'h800000); expq.push_back(25'h0800000);
    chk("b2b:ready3", 64'(ready_w[0]), 64'(1));
    wait_frames("b2b", 3, 500);
    check_frames("b2b", 0, 2, 1'b1);
    wait_idle("b2b", 0, 300);

    // Overflow: six consecutive strobes, the sixth hits a full FIFO
    for (int k = 0; k < 6; k++) cw[k] = 24'($urandom());
    for (int k = 0; k < 6; k++) begin
      if (k == 5) chk("ovf:ready_full", 64'(ready_w[0]), 64'(0));
      drive(0, 1'b1, 1'b1, cw[k]);
      if (k < 5) expq.push_back({1'b1, cw[k]});
      if (k == 4) chk("ovf:no_pulse_yet", 64'(ovf_w[0]), 64'(0));
      if (k == 5) chk("ovf:pulse", 64'(ovf_w[0]), 64'(1));
    end
    @(posedge clk);
    #1;
    chk("ovf:pulse_end", 64'(ovf_w[0]), 64'(0));
    wait_frames("ovf", 5, 800);
    wait_idle("ovf", 0, 400);
    check_frames("ovf", 0, 2, 1'b1);

    // Random bursts on the CLK_DIV=2 instance
    for (int r = 0; r < 5; r++) begin
      int burst = int'($urandom_range(1, 3));
      for (int b = 0; b < burst; b++) begin
        c = 24'($urandom());
        m = 1'($urandom());
        drive(0, 1'b1, m, c);
        expq.push_back({m, c});
      end
      wait_idle("rand0", 0, 1000);
      repeat ($urandom_range(0, 4)) @(posedge clk);
      #1;
    end
    check_frames("rand0", 0, 2, 1'b0);

    // CLK_DIV=1 instance: directed word then random words
    drive(1, 1'b1, 1'b0, 24'hA5A5A5);
    expq.push_back(25'h0A5A5A5);
    wait_idle("div1", 1, 200);
    for (int r = 0; r < 4; r++) begin
      c = 24'($urandom());
      m = 1'($urandom());
      drive(1, 1'b1, m, c);
      expq.push_back({m, c});
      wait_idle("div1r", 1, 200);
    end
    check_frames("div1", 1, 1, 1'b0);

    // Reset mid-frame with two words still queued
    for (int k = 0; k < 3; k++) drive(0, 1'b1, 1'b0, 24'($urandom()));
    rises = 0; t = 0; ps = sclk_w[0];
    while (rises < 10 && t < 400) begin
      @(negedge clk);
      if (!cs_w[0] && sclk_w[0] && !ps) rises++;
      ps = sclk_w[0];
      t++;
    end
    chk("midrst:rise_timeout", 64'(rises), 64'(10));
    #2;
    nrst = 1'b0;
    #1;
    chk("midrst:cs_n", 64'(cs_w[0]), 64'(1));
    chk("midrst:sclk", 64'(sclk_w[0]), 64'(0));
    chk("midrst:mosi", 64'(mosi_w[0]), 64'(0));
    chk("midrst:busy", 64'(busy_w[0]), 64'(0));
    chk("midrst:ready", 64'(ready_w[0]), 64'(1));
    repeat (3) @(posedge clk);
    #1;
    nrst = 1'b1;
    repeat (400) @(posedge clk);
    #1;
    chk("midrst:frames", 64'(frames.size()), 64'(1));
    if (frames.size() > 0) chk("midrst:partial_bits", 64'(frames[0].bits), 64'(10));
    chk("midrst:busy_after", 64'(busy_w[0]), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
